// File: rtl/bist_pkg.sv
// Shared March C- sequencing types and per-element constants for the BIST controller.
package bist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int unsigned ELEM_W = 3;
  typedef logic [ELEM_W-1:0] elem_t;

  localparam elem_t ELEM_LAST = 3'd5;

  // Bit k of each mask describes element Mk.
  localparam logic [7:0] ELEM_PAIRED = 8'b0001_1110;  // read then write at each address
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;  // address runs N-1..0
  localparam logic [7:0] ELEM_WBIT   = 8'b0000_1010;  // value written (replicated)
  localparam logic [7:0] ELEM_RBIT   = 8'b0001_0100;  // value expected on read (replicated)

  function automatic elem_t state_elem(input state_e s);
    case (s)
      ST_M1:   return 3'd1;
      ST_M2:   return 3'd2;
      ST_M3:   return 3'd3;
      ST_M4:   return 3'd4;
      ST_M5:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic state_e elem_state(input elem_t e);
    case (e)
      3'd1:    return ST_M1;
      3'd2:    return ST_M2;
      3'd3:    return ST_M3;
      3'd4:    return ST_M4;
      3'd5:    return ST_M5;
      default: return ST_M0;
    endcase
  endfunction

endpackage

// File: rtl/bist_addr_counter.sv
// Loadable up/down address counter with a terminal-address flag for the current direction.
module bist_addr_counter #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  en,
  input  logic                  down,
  output logic [ADDR_WIDTH-1:0] count_next_c,
  output logic                  last_c
);

  logic [ADDR_WIDTH-1:0] count_q;

  always_comb begin
    count_next_c = count_q;
    if (load) begin
      count_next_c = load_val;
    end else if (en) begin
      count_next_c = down ? count_q - ADDR_WIDTH'(1) : count_q + ADDR_WIDTH'(1);
    end
  end

  assign last_c = down ? (count_q == '0) : (count_q == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_next_c;
    end
  end

endmodule

// File: rtl/bist_controller.sv
// March C- memory BIST controller: sequences the six elements, drives the memory
// multiplexer and checks read data one cycle after each read strobe.
module bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  Nbart,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  we,
  output logic                  re,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;
  logic                  start_q;
  elem_t                 e, ne;

  logic                  cnt_load, cnt_en, cnt_down, cnt_last;
  logic [ADDR_WIDTH-1:0] cnt_load_val, cnt_next;

  logic                  nbart_d, we_d, re_d, done_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, exp_d, exp_q;

  logic                  chk_valid_q;
  logic [DATA_WIDTH-1:0] chk_exp_q;
  logic [ADDR_WIDTH-1:0] chk_addr_q;
  logic                  restart;

  assign e        = state_elem(state_q);
  assign ne       = state_elem(state_d);
  assign cnt_down = ELEM_DOWN[e];
  assign restart  = (state_q == ST_DONE) && (state_d == ST_M0);

  bist_addr_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (cnt_load),
    .load_val     (cnt_load_val),
    .en           (cnt_en),
    .down         (cnt_down),
    .count_next_c (cnt_next),
    .last_c       (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      start_q <= start;
    end
  end

  // Element sequencing; start is only looked at in IDLE and DONE.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_q) begin
          state_d  = ST_M0;
          phase_d  = 1'b0;
          cnt_load = 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      default: begin
        if (ELEM_PAIRED[e]) begin
          phase_d = ~phase_q;
        end
        if (!ELEM_PAIRED[e] || phase_q) begin
          if (cnt_last) begin
            phase_d = 1'b0;
            if (e == ELEM_LAST) begin
              state_d = ST_FLUSH;
            end else begin
              state_d      = elem_state(e + 3'd1);
              cnt_load     = 1'b1;
              cnt_load_val = ELEM_DOWN[e + 3'd1] ? '1 : '0;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
    endcase
  end

  // Operation decode from the upcoming state so the strobes leave a register.
  always_comb begin
    nbart_d = 1'b0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    done_d  = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    exp_d   = '0;
    case (state_d)
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
        nbart_d = 1'b1;
        re_d    = (ELEM_PAIRED[ne] && !phase_d) || (ne == ELEM_LAST);
        we_d    = !re_d;
        addr_d  = cnt_next;
        wdata_d = (we_d && ELEM_WBIT[ne]) ? '1 : '0;
        exp_d   = (re_d && ELEM_RBIT[ne]) ? '1 : '0;
      end
      ST_FLUSH: nbart_d = 1'b1;
      ST_DONE:  done_d  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Nbart <= 1'b0;
      we    <= 1'b0;
      re    <= 1'b0;
      done  <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      exp_q <= '0;
    end else begin
      Nbart <= nbart_d;
      we    <= we_d;
      re    <= re_d;
      done  <= done_d;
      addr  <= addr_d;
      wdata <= wdata_d;
      exp_q <= exp_d;
    end
  end

  // Read check: expectation trails the strobe by one cycle to meet the returning data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_valid_q <= 1'b0;
      chk_exp_q   <= '0;
      chk_addr_q  <= '0;
      fail        <= 1'b0;
      fail_addr   <= '0;
    end else begin
      chk_valid_q <= re;
      chk_exp_q   <= exp_q;
      chk_addr_q  <= addr;
      if (restart) begin
        fail      <= 1'b0;
        fail_addr <= '0;
      end else if (chk_valid_q && (rdata != chk_exp_q) && !fail) begin
        fail      <= 1'b1;
        fail_addr <= chk_addr_q;
      end
    end
  end

endmodule
